// File: rtl/viterbi_cs_sched.sv
// viterbi_cs_sched
// ----------------
// Sequencing controller for the Viterbi compare-select datapath. Symbols are
// accepted one at a time. The first symbol of a frame is issued to first_cs
// (first_go) and every later symbol to cs (cs_go). The results of the matching
// datapath are captured into the survivor path-metric and path-history
// registers, which feed back into cs. When any captured metric reaches
// NORM_THRESH, the minimum metric is subtracted from all four so that the
// 4-bit metrics never overflow. When the last symbol of a frame is captured,
// tb_start pulses to hand the frame to the traceback unit.
//
// Parameters
//   FRAME_LEN    symbols per frame (2..255)
//   NORM_THRESH  metric value at or above which normalisation triggers
//   TIMEOUT      maximum number of cycles spent waiting for a datapath done
//
// Ports
//   clk, rst                  clock; synchronous active-low reset
//   sym_valid, frame_start    symbol handshake in; frame_start marks symbol 0
//   sym_ready                 controller can accept a symbol this cycle
//   first_go / cs_go          one-cycle issue strobes to first_cs / cs
//   first_done / cs_done      valid_out of first_cs / cs
//   first_bm_xx, first_path_xx  first_cs results (4-bit metric, 3-bit path)
//   cs_bm_xx, cs_path_xx      cs results (4-bit metric, 8-bit path)
//   pm_xx, path_xx            stored survivor metrics / path history
//   sym_cnt                   symbols completed in the current frame
//   norm_event                pulse: the last capture was normalised
//   tb_start                  pulse: frame complete
//   proto_err                 pulse: framing violation
//   timeout_err               sticky: the datapath failed to answer in time
module viterbi_cs_sched #(
  parameter int FRAME_LEN   = 8,
  parameter int NORM_THRESH = 8,
  parameter int TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic       frame_start,
  output logic       sym_ready,
  output logic       first_go,
  output logic       cs_go,
  input  logic       first_done,
  input  logic       cs_done,
  input  logic [3:0] first_bm_00,
  input  logic [3:0] first_bm_01,
  input  logic [3:0] first_bm_10,
  input  logic [3:0] first_bm_11,
  input  logic [2:0] first_path_00,
  input  logic [2:0] first_path_01,
  input  logic [2:0] first_path_10,
  input  logic [2:0] first_path_11,
  input  logic [3:0] cs_bm_00,
  input  logic [3:0] cs_bm_01,
  input  logic [3:0] cs_bm_10,
  input  logic [3:0] cs_bm_11,
  input  logic [7:0] cs_path_00,
  input  logic [7:0] cs_path_01,
  input  logic [7:0] cs_path_10,
  input  logic [7:0] cs_path_11,
  output logic [3:0] pm_00,
  output logic [3:0] pm_01,
  output logic [3:0] pm_10,
  output logic [3:0] pm_11,
  output logic [7:0] path_00,
  output logic [7:0] path_01,
  output logic [7:0] path_10,
  output logic [7:0] path_11,
  output logic [7:0] sym_cnt,
  output logic       norm_event,
  output logic       tb_start,
  output logic       proto_err,
  output logic       timeout_err
);

  localparam logic [7:0] FRAME_LEN_C = 8'(FRAME_LEN);
  localparam logic [7:0] WAIT_LAST_C = 8'(TIMEOUT - 1);
  localparam logic [4:0] NORM_THR_C  = 5'(NORM_THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_READY,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       first_sel_q, first_sel_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] sym_cnt_q, sym_cnt_d;
  logic       norm_q, norm_d;
  logic       proto_q, proto_d;
  logic       tout_q, tout_d;
  // Low while reset is held and for the cycle in which it is sampled; keeps
  // sym_ready low until the first cycle after reset is released.
  logic       alive_q;

  logic [3:0] pm_q   [4];
  logic [3:0] pm_d   [4];
  logic [7:0] path_q [4];
  logic [7:0] path_d [4];

  // Lane-indexed views of the two datapath result buses.
  logic [3:0] first_bm   [4];
  logic [2:0] first_path [4];
  logic [3:0] cs_bm      [4];
  logic [7:0] cs_path    [4];

  assign first_bm[0]   = first_bm_00;
  assign first_bm[1]   = first_bm_01;
  assign first_bm[2]   = first_bm_10;
  assign first_bm[3]   = first_bm_11;
  assign first_path[0] = first_path_00;
  assign first_path[1] = first_path_01;
  assign first_path[2] = first_path_10;
  assign first_path[3] = first_path_11;
  assign cs_bm[0]      = cs_bm_00;
  assign cs_bm[1]      = cs_bm_01;
  assign cs_bm[2]      = cs_bm_10;
  assign cs_bm[3]      = cs_bm_11;
  assign cs_path[0]    = cs_path_00;
  assign cs_path[1]    = cs_path_01;
  assign cs_path[2]    = cs_path_10;
  assign cs_path[3]    = cs_path_11;

  // Capture candidates: the bus of the datapath that was actually issued.
  logic [3:0] cap_bm    [4];
  logic [7:0] cap_path  [4];
  logic [3:0] norm_bm   [4];
  logic [3:0] need_norm;
  logic [3:0] min_lo, min_hi, bm_min;
  logic       do_norm;
  logic       done_hit;
  logic [7:0] sym_cnt_inc;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign cap_bm[gi]    = first_sel_q ? first_bm[gi] : cs_bm[gi];
    assign cap_path[gi]  = first_sel_q ? {5'b00000, first_path[gi]} : cs_path[gi];
    assign need_norm[gi] = ({1'b0, cap_bm[gi]} >= NORM_THR_C);
    // bm_min is never larger than any lane, so this cannot wrap.
    assign norm_bm[gi]   = cap_bm[gi] - bm_min;
  end

  assign min_lo      = (cap_bm[0] < cap_bm[1]) ? cap_bm[0] : cap_bm[1];
  assign min_hi      = (cap_bm[2] < cap_bm[3]) ? cap_bm[2] : cap_bm[3];
  assign bm_min      = (min_lo < min_hi) ? min_lo : min_hi;
  assign do_norm     = |need_norm;
  // Only the done of the datapath that was issued counts.
  assign done_hit    = first_sel_q ? first_done : cs_done;
  assign sym_cnt_inc = sym_cnt_q + 8'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      first_sel_q <= 1'b0;
      wait_cnt_q  <= 8'd0;
      sym_cnt_q   <= 8'd0;
      norm_q      <= 1'b0;
      proto_q     <= 1'b0;
      tout_q      <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_sel_q <= first_sel_d;
      wait_cnt_q  <= wait_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      norm_q      <= norm_d;
      proto_q     <= proto_d;
      tout_q      <= tout_d;
      alive_q     <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_store
    always_ff @(posedge clk) begin
      if (!rst) begin
        pm_q[gi]   <= 4'd0;
        path_q[gi] <= 8'd0;
      end else begin
        pm_q[gi]   <= pm_d[gi];
        path_q[gi] <= path_d[gi];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    first_sel_d = first_sel_q;
    wait_cnt_d  = wait_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    norm_d      = 1'b0;
    proto_d     = 1'b0;
    tout_d      = tout_q;
    for (int i = 0; i < 4; i++) begin
      pm_d[i]   = pm_q[i];
      path_d[i] = path_q[i];
    end

    case (state_q)
      S_IDLE, S_READY: begin
        if (sym_valid) begin
          if (frame_start) begin
            // A frame start in READY abandons the current frame.
            proto_d     = (state_q == S_READY);
            sym_cnt_d   = 8'd0;
            tout_d      = 1'b0;
            first_sel_d = 1'b1;
            state_d     = S_ISSUE;
            for (int i = 0; i < 4; i++) begin
              pm_d[i]   = 4'd0;
              path_d[i] = 8'd0;
            end
          end else if (state_q == S_READY) begin
            first_sel_d = 1'b0;
            state_d     = S_ISSUE;
          end else begin
            // Mid-frame symbol with no frame open: consume and flag it.
            proto_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        wait_cnt_d = 8'd0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (done_hit) begin
          for (int i = 0; i < 4; i++) begin
            pm_d[i]   = do_norm ? norm_bm[i] : cap_bm[i];
            path_d[i] = cap_path[i];
          end
          norm_d    = do_norm;
          sym_cnt_d = sym_cnt_inc;
          state_d   = (sym_cnt_inc == FRAME_LEN_C) ? S_DONE : S_READY;
        end else if (wait_cnt_q == WAIT_LAST_C) begin
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sym_ready = 1'b0;
    first_go  = 1'b0;
    cs_go     = 1'b0;
    tb_start  = 1'b0;
    case (state_q)
      S_IDLE, S_READY: sym_ready = alive_q;
      S_ISSUE: begin
        first_go = first_sel_q;
        cs_go    = !first_sel_q;
      end
      S_DONE:  tb_start = 1'b1;
      default: begin
      end
    endcase
  end

  assign pm_00       = pm_q[0];
  assign pm_01       = pm_q[1];
  assign pm_10       = pm_q[2];
  assign pm_11       = pm_q[3];
  assign path_00     = path_q[0];
  assign path_01     = path_q[1];
  assign path_10     = path_q[2];
  assign path_11     = path_q[3];
  assign sym_cnt     = sym_cnt_q;
  assign norm_event  = norm_q;
  assign proto_err   = proto_q;
  assign timeout_err = tout_q;

endmodule
